// File: rtl/soc_decode_bb_pipe_if.sv
// Master-side Blackbone bus between a CPU data port and soc_decode_bb_pipe.
//   master modport : drives addr/din/sel/en/we, receives ready/ack/err/dout
//   slave  modport : the decoder side of the same bus
// Signals:
//   addr  [ADDR_WIDTH]   access address
//   din   [DATA_WIDTH]   write data
//   sel   [DATA_WIDTH/8] byte selects
//   en    1              request
//   we    1              1=write, 0=read
//   ready 1              decoder can accept a request
//   ack   1              one-cycle completion pulse
//   err   1              one-cycle failure pulse
//   dout  [DATA_WIDTH]   read data, valid with ack
interface soc_decode_bb_pipe_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   din;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    en;
  logic                    we;
  logic                    ready;
  logic                    ack;
  logic                    err;
  logic [DATA_WIDTH-1:0]   dout;

  modport master (
    output addr, din, sel, en, we,
    input  ready, ack, err, dout
  );

  modport slave (
    input  addr, din, sel, en, we,
    output ready, ack, err, dout
  );
endinterface

// File: rtl/soc_decode_bb_pipe.sv
// Registered Blackbone address decoder: one master, SLAVES slaves.
// An accepted access is latched and held on exactly one slave until that slave
// acknowledges it; decode errors (no match / multiple match) and, optionally,
// slave timeouts are reported to the master as a one-cycle err pulse.
// Optional feature macro: SOC_DECODE_BB_TIMEOUT_EN (adds the ACCESS timeout counter).
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   m_bus          master bus (soc_decode_bb_pipe_if.slave)
//   err_addr_o     address of the last failed access (sticky)
//   err_code_o     00 none, 01 no match, 10 multiple match, 11 timeout (sticky)
//   s_addr_o, s_din_o, s_sel_o, s_we_o  latched access fields, replicated per slave
//   s_en_o         per-slave request, at most one bit high
//   s_ack_i        per-slave completion, read data valid in the same cycle
//   s_dout_i       per-slave read data
module soc_decode_bb_pipe #(
  parameter int                           SLAVES         = 4,
  parameter int                           DATA_WIDTH     = 32,
  parameter int                           ADDR_WIDTH     = 32,
  parameter logic [SLAVES-1:0]            S_ENABLE       = {SLAVES{1'b1}},
  parameter logic [SLAVES*8-1:0]          S_RANGE_WIDTH  = {SLAVES{8'd1}},
  parameter logic [SLAVES*ADDR_WIDTH-1:0] S_RANGE_MATCH  = {(SLAVES*ADDR_WIDTH){1'b0}},
  parameter int                           TIMEOUT_CYCLES = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  soc_decode_bb_pipe_if.slave            m_bus,
  output logic [ADDR_WIDTH-1:0]          err_addr_o,
  output logic [1:0]                     err_code_o,
  output logic [SLAVES*ADDR_WIDTH-1:0]   s_addr_o,
  output logic [SLAVES*DATA_WIDTH-1:0]   s_din_o,
  output logic [SLAVES*DATA_WIDTH/8-1:0] s_sel_o,
  output logic [SLAVES-1:0]              s_we_o,
  output logic [SLAVES-1:0]              s_en_o,
  input  logic [SLAVES-1:0]              s_ack_i,
  input  logic [SLAVES*DATA_WIDTH-1:0]   s_dout_i
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_e;

  // Elaboration-time parameter sanity checks
  if (SLAVES < 1 || SLAVES > 16) begin : g_bad_slaves
    $error("soc_decode_bb_pipe: SLAVES must be 1..16");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("soc_decode_bb_pipe: DATA_WIDTH must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("soc_decode_bb_pipe: TIMEOUT_CYCLES must be >= 2");
  end

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic                    we_q, we_d;
  logic [SLAVES-1:0]       s_en_q, s_en_d;

  logic [SLAVES-1:0]       match_s;
  logic                    any_s, multi_s, ack_hit_s;
  logic [DATA_WIDTH-1:0]   rdata_s;

`ifdef SOC_DECODE_BB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Range compare: slave k matches when its top RW address bits equal its match value
  for (genvar k = 0; k < SLAVES; k++) begin : g_dec
    localparam int RW = int'(S_RANGE_WIDTH[k*8 +: 8]);
    localparam logic [ADDR_WIDTH-1:0] MV = S_RANGE_MATCH[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign match_s[k] = S_ENABLE[k] & ((m_bus.addr >> (ADDR_WIDTH - RW)) == MV);
  end

  // Match classification, selected-slave ack and read-data mux (s_en_q is one-hot)
  always_comb begin
    any_s   = 1'b0;
    multi_s = 1'b0;
    rdata_s = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < SLAVES; k++) begin
      multi_s = multi_s | (any_s & match_s[k]);
      any_s   = any_s | match_s[k];
      rdata_s = rdata_s | (s_dout_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{s_en_q[k]}});
    end
    ack_hit_s = |(s_ack_i & s_en_q);
  end

  // Next-state and next-output computation of the decode FSM
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dout_d     = {DATA_WIDTH{1'b0}};
    err_addr_d = err_addr_q;
    err_code_d = err_code_q;
    addr_d     = addr_q;
    din_d      = din_q;
    sel_d      = sel_q;
    we_d       = we_q;
    s_en_d     = s_en_q;
`ifdef SOC_DECODE_BB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (m_bus.en && ready_q) begin
          if (any_s && !multi_s) begin
            addr_d  = m_bus.addr;
            din_d   = m_bus.din;
            sel_d   = m_bus.sel;
            we_d    = m_bus.we;
            s_en_d  = match_s;
            state_d = ST_ACCESS;
`ifdef SOC_DECODE_BB_TIMEOUT_EN
            cnt_d   = {CNT_W{1'b0}};
`endif
          end else begin
            err_d      = 1'b1;
            err_addr_d = m_bus.addr;
            err_code_d = any_s ? 2'b10 : 2'b01;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (ack_hit_s) begin
          // Ack is checked first so an ack in the terminal cycle beats the timeout
          s_en_d  = {SLAVES{1'b0}};
          ack_d   = 1'b1;
          dout_d  = we_q ? {DATA_WIDTH{1'b0}} : rdata_s;
          state_d = ST_IDLE;
        end else begin
`ifdef SOC_DECODE_BB_TIMEOUT_EN
          if (cnt_q == TO_LAST) begin
            s_en_d     = {SLAVES{1'b0}};
            err_d      = 1'b1;
            err_addr_d = addr_q;
            err_code_d = 2'b11;
            state_d    = ST_IDLE;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`else
          state_d = ST_ACCESS;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_en_d  = {SLAVES{1'b0}};
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; async reset aborts any access in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= {DATA_WIDTH{1'b0}};
      err_addr_q <= {ADDR_WIDTH{1'b0}};
      err_code_q <= 2'b00;
      addr_q     <= {ADDR_WIDTH{1'b0}};
      din_q      <= {DATA_WIDTH{1'b0}};
      sel_q      <= {SEL_WIDTH{1'b0}};
      we_q       <= 1'b0;
      s_en_q     <= {SLAVES{1'b0}};
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
      err_addr_q <= err_addr_d;
      err_code_q <= err_code_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      s_en_q     <= s_en_d;
    end
  end

`ifdef SOC_DECODE_BB_TIMEOUT_EN
  // ACCESS cycle counter for the slave timeout
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign m_bus.ready = ready_q;
  assign m_bus.ack   = ack_q;
  assign m_bus.err   = err_q;
  assign m_bus.dout  = dout_q;
  assign err_addr_o  = err_addr_q;
  assign err_code_o  = err_code_q;
  assign s_addr_o    = {SLAVES{addr_q}};
  assign s_din_o     = {SLAVES{din_q}};
  assign s_sel_o     = {SLAVES{sel_q}};
  assign s_we_o      = {SLAVES{we_q}};
  assign s_en_o      = s_en_q;
endmodule

// File: tb/tb_soc_decode_bb_pipe.sv
// Directed testbench for soc_decode_bb_pipe.
// Map: S0 nibble 0x0, S1 nibble 0x8, S2 nibble 0xC, S3 top two bits 2'b11
// (S2/S3 overlap on 0xC..., S3 alone on 0xD..0xF, nothing on 0x4...).
module tb_soc_decode_bb_pipe;
  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [31:0]   err_addr_o;
  logic [1:0]    err_code_o;
  logic [127:0]  s_addr_o;
  logic [127:0]  s_din_o;
  logic [15:0]   s_sel_o;
  logic [3:0]    s_we_o;
  logic [3:0]    s_en_o;
  logic [3:0]    s_ack_i;
  logic [127:0]  s_dout_i;
  int            checks = 0;
  int            errors = 0;

  soc_decode_bb_pipe_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

  soc_decode_bb_pipe #(
    .SLAVES         (4),
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .S_ENABLE       (4'b1111),
    .S_RANGE_WIDTH  ({8'd2, 8'd4, 8'd4, 8'd4}),
    .S_RANGE_MATCH  ({32'h3, 32'hC, 32'h8, 32'h0}),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .m_bus      (m_if.slave),
    .err_addr_o (err_addr_o),
    .err_code_o (err_code_o),
    .s_addr_o   (s_addr_o),
    .s_din_o    (s_din_o),
    .s_sel_o    (s_sel_o),
    .s_we_o     (s_we_o),
    .s_en_o     (s_en_o),
    .s_ack_i    (s_ack_i),
    .s_dout_i   (s_dout_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    checks++; if (m_if.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0h want 1", m_if.ready); end
    checks++; if (m_if.ack !== 1'b0 || m_if.err !== 1'b0) begin errors++; $display("FAIL rst_ack_err: got %0h/%0h want 0/0", m_if.ack, m_if.err); end
    checks++; if (s_en_o !== 4'b0000) begin errors++; $display("FAIL rst_s_en: got %b want 0000", s_en_o); end
    checks++; if (m_if.dout !== 32'h0 || err_code_o !== 2'b00 || err_addr_o !== 32'h0) begin errors++; $display("FAIL rst_regs: dout %h code %b eaddr %h want 0", m_if.dout, err_code_o, err_addr_o); end
    checks++; if (s_addr_o !== 128'h0 || s_we_o !== 4'b0000) begin errors++; $display("FAIL rst_slave_fields: got %h %b want 0", s_addr_o, s_we_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    checks++; if (m_if.ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %0h want 1", m_if.ready); end
  endtask

  task automatic test_read_slow_ack();
    m_if.addr = 32'h8000_0010; m_if.we = 1'b0; m_if.sel = 4'hF; m_if.din = 32'h0; m_if.en = 1'b1;
    step();
    checks++; if (s_en_o !== 4'b0010) begin errors++; $display("FAIL read_s_en_c1: got %b want 0010", s_en_o); end
    checks++; if (m_if.ready !== 1'b0) begin errors++; $display("FAIL read_ready_busy: got %0h want 0", m_if.ready); end
    checks++; if (s_addr_o[63:32] !== 32'h8000_0010 || s_we_o !== 4'b0000) begin errors++; $display("FAIL read_s_addr: got %h we %b want 80000010 0000", s_addr_o[63:32], s_we_o); end
    m_if.en = 1'b0;
    s_ack_i = 4'b0001;
    step();
    checks++; if (s_en_o !== 4'b0010 || m_if.ack !== 1'b0) begin errors++; $display("FAIL read_stray_ack: s_en %b ack %0h want 0010 0", s_en_o, m_if.ack); end
    s_ack_i = 4'b0000;
    step();
    checks++; if (s_en_o !== 4'b0010) begin errors++; $display("FAIL read_s_en_c3: got %b want 0010", s_en_o); end
    s_ack_i = 4'b0010; s_dout_i[63:32] = 32'hDEAD_BEEF;
    step();
    checks++; if (m_if.ack !== 1'b1 || m_if.err !== 1'b0) begin errors++; $display("FAIL read_ack: got ack %0h err %0h want 1 0", m_if.ack, m_if.err); end
    checks++; if (m_if.dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_dout: got %h want deadbeef", m_if.dout); end
    checks++; if (s_en_o !== 4'b0000 || m_if.ready !== 1'b1) begin errors++; $display("FAIL read_release: s_en %b ready %0h want 0000 1", s_en_o, m_if.ready); end
    s_ack_i = 4'b0000; s_dout_i = 128'h0;
    step();
    checks++; if (m_if.ack !== 1'b0 || m_if.dout !== 32'h0) begin errors++; $display("FAIL read_ack_pulse: ack %0h dout %h want 0 0", m_if.ack, m_if.dout); end
  endtask

  task automatic test_write_fast_ack();
    m_if.addr = 32'h0000_0004; m_if.din = 32'h1234_5678; m_if.sel = 4'b0101; m_if.we = 1'b1; m_if.en = 1'b1;
    step();
    checks++; if (s_en_o !== 4'b0001) begin errors++; $display("FAIL wr_s_en: got %b want 0001", s_en_o); end
    checks++; if (s_din_o[31:0] !== 32'h1234_5678 || s_sel_o[3:0] !== 4'b0101 || s_we_o !== 4'b1111) begin errors++; $display("FAIL wr_fields: din %h sel %b we %b want 12345678 0101 1111", s_din_o[31:0], s_sel_o[3:0], s_we_o); end
    checks++; if (m_if.ack !== 1'b0) begin errors++; $display("FAIL wr_early_ack: got %0h want 0", m_if.ack); end
    m_if.en = 1'b0;
    s_ack_i = 4'b0001; s_dout_i[31:0] = 32'hFFFF_FFFF;
    step();
    checks++; if (m_if.ack !== 1'b1 || m_if.dout !== 32'h0 || s_en_o !== 4'b0000) begin errors++; $display("FAIL wr_ack: ack %0h dout %h s_en %b want 1 0 0000", m_if.ack, m_if.dout, s_en_o); end
    // New request presented in the ack cycle
    s_ack_i = 4'b0000; s_dout_i = 128'h0;
    m_if.addr = 32'h8000_0020; m_if.we = 1'b0; m_if.en = 1'b1;
    step();
    checks++; if (s_en_o !== 4'b0010 || m_if.ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_accept: s_en %b ack %0h want 0010 0", s_en_o, m_if.ack); end
    m_if.en = 1'b0;
    s_ack_i = 4'b0010; s_dout_i[63:32] = 32'h0BAD_F00D;
    step();
    checks++; if (m_if.ack !== 1'b1 || m_if.dout !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_ack_read: ack %0h dout %h want 1 0badf00d", m_if.ack, m_if.dout); end
    s_ack_i = 4'b0000; s_dout_i = 128'h0;
    step();
  endtask

  task automatic test_no_match();
    m_if.addr = 32'h4000_0000; m_if.we = 1'b0; m_if.en = 1'b1;
    step();
    checks++; if (m_if.err !== 1'b1 || m_if.ack !== 1'b0) begin errors++; $display("FAIL nm_err: err %0h ack %0h want 1 0", m_if.err, m_if.ack); end
    checks++; if (err_code_o !== 2'b01 || err_addr_o !== 32'h4000_0000) begin errors++; $display("FAIL nm_code: code %b addr %h want 01 40000000", err_code_o, err_addr_o); end
    checks++; if (s_en_o !== 4'b0000 || m_if.ready !== 1'b1 || m_if.dout !== 32'h0) begin errors++; $display("FAIL nm_side: s_en %b ready %0h dout %h want 0000 1 0", s_en_o, m_if.ready, m_if.dout); end
    m_if.en = 1'b0;
    step();
    checks++; if (m_if.err !== 1'b0 || err_code_o !== 2'b01) begin errors++; $display("FAIL nm_sticky: err %0h code %b want 0 01", m_if.err, err_code_o); end
  endtask

  task automatic test_multi_back_to_back();
    m_if.addr = 32'hC000_0000; m_if.we = 1'b0; m_if.en = 1'b1;
    step();
    checks++; if (m_if.err !== 1'b1 || err_code_o !== 2'b10 || err_addr_o !== 32'hC000_0000) begin errors++; $display("FAIL multi_err: err %0h code %b addr %h want 1 10 c0000000", m_if.err, err_code_o, err_addr_o); end
    checks++; if (s_en_o !== 4'b0000 || m_if.ready !== 1'b1) begin errors++; $display("FAIL multi_side: s_en %b ready %0h want 0000 1", s_en_o, m_if.ready); end
    m_if.addr = 32'hF000_0004;
    step();
    checks++; if (s_en_o !== 4'b1000 || m_if.err !== 1'b0 || m_if.ready !== 1'b0) begin errors++; $display("FAIL b2b_err_accept: s_en %b err %0h ready %0h want 1000 0 0", s_en_o, m_if.err, m_if.ready); end
    m_if.en = 1'b0;
    s_ack_i = 4'b1000; s_dout_i[127:96] = 32'hA5A5_0F0F;
    step();
    checks++; if (m_if.ack !== 1'b1 || m_if.dout !== 32'hA5A5_0F0F || m_if.err !== 1'b0) begin errors++; $display("FAIL s3_ack: ack %0h dout %h err %0h want 1 a5a50f0f 0", m_if.ack, m_if.dout, m_if.err); end
    checks++; if (err_code_o !== 2'b10) begin errors++; $display("FAIL multi_sticky: got %b want 10", err_code_o); end
    s_ack_i = 4'b0000; s_dout_i = 128'h0;
    step();
  endtask

`ifdef SOC_DECODE_BB_TIMEOUT_EN
  task automatic test_timeout();
    m_if.addr = 32'h0000_0100; m_if.we = 1'b0; m_if.en = 1'b1;
    step();
    m_if.en = 1'b0;
    step(); step(); step();
    checks++; if (s_en_o !== 4'b0001 || m_if.err !== 1'b0) begin errors++; $display("FAIL to_c4: s_en %b err %0h want 0001 0", s_en_o, m_if.err); end
    step();
    checks++; if (m_if.err !== 1'b1 || err_code_o !== 2'b11 || err_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL to_err: err %0h code %b addr %h want 1 11 00000100", m_if.err, err_code_o, err_addr_o); end
    checks++; if (s_en_o !== 4'b0000 || m_if.ack !== 1'b0) begin errors++; $display("FAIL to_drop: s_en %b ack %0h want 0000 0", s_en_o, m_if.ack); end
    step();
    m_if.en = 1'b1;
    step();
    m_if.en = 1'b0;
    step(); step(); step();
    s_ack_i = 4'b0001;
    step();
    checks++; if (m_if.ack !== 1'b1 || m_if.err !== 1'b0) begin errors++; $display("FAIL to_ack_wins: ack %0h err %0h want 1 0", m_if.ack, m_if.err); end
    s_ack_i = 4'b0000;
    step();
  endtask
`endif

  task automatic test_reset_mid_access();
    m_if.addr = 32'h8000_0000; m_if.we = 1'b0; m_if.en = 1'b1;
    step();
    checks++; if (s_en_o !== 4'b0010) begin errors++; $display("FAIL mid_s_en: got %b want 0010", s_en_o); end
    m_if.en = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (s_en_o !== 4'b0000 || m_if.ack !== 1'b0 || m_if.err !== 1'b0) begin errors++; $display("FAIL mid_abort: s_en %b ack %0h err %0h want 0000 0 0", s_en_o, m_if.ack, m_if.err); end
    checks++; if (s_addr_o !== 128'h0 || err_code_o !== 2'b00 || err_addr_o !== 32'h0) begin errors++; $display("FAIL mid_clear: addr %h code %b eaddr %h want 0", s_addr_o, err_code_o, err_addr_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    checks++; if (m_if.ready !== 1'b1 || s_en_o !== 4'b0000 || m_if.ack !== 1'b0) begin errors++; $display("FAIL mid_release: ready %0h s_en %b ack %0h want 1 0000 0", m_if.ready, s_en_o, m_if.ack); end
  endtask

  initial begin
    rst_ni = 1'b0;
    m_if.addr = 32'h0; m_if.din = 32'h0; m_if.sel = 4'h0; m_if.en = 1'b0; m_if.we = 1'b0;
    s_ack_i = 4'b0000; s_dout_i = 128'h0;
    test_reset();
    test_read_slow_ack();
    test_write_fast_ack();
    test_no_match();
    test_multi_back_to_back();
`ifdef SOC_DECODE_BB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
